serial_bit_tx: RTL and testbench

Parallel-to-serial bit transmitter that produces the single-bit serial stream consumed by the team's serial FSM blocks (their `in` input).
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per clock and pulses `done` when the frame ends.
- Serves as the driving end of the serial FSM interface, in benches and in the datapath.

---
 rtl/serial_bit_tx_if.sv | 22 ++
 rtl/serial_bit_tx.sv | 115 +++++++++++
 tb/tb_serial_bit_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_tx_if.sv
// Load handshake and serial output bundle for serial_bit_tx.
// master drives words in; slave is the transmitter side.
interface serial_bit_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_active;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_active, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_active, done
    );
endinterface

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per frame, one bit per clock, done pulse at end.
// Optional even-parity bit after the data bits when SERIAL_BIT_TX_PARITY_EN is defined.
module serial_bit_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 0
) (
    input logic            clk,
    input logic            rst_n,
    serial_bit_tx_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef SERIAL_BIT_TX_PARITY_EN
        PAR   = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             ser_out_q;
    logic             ser_active_q;
    logic             done_q;
    logic             ready_q;
`ifdef SERIAL_BIT_TX_PARITY_EN
    logic             parity_q;
`endif

    assign bus.ser_out    = ser_out_q;
    assign bus.ser_active = ser_active_q;
    assign bus.done       = done_q;
    assign bus.load_ready = ready_q;

    // cnt holds the number of bits already placed on ser_out in this frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            ser_out_q    <= 1'b0;
            ser_active_q <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
`ifdef SERIAL_BIT_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        state        <= SHIFT;
                        ready_q      <= 1'b0;
                        ser_active_q <= 1'b1;
                        cnt          <= CW'(1);
                        if (MSB_FIRST != 0) begin
                            ser_out_q <= bus.load_data[WIDTH-1];
                            shreg     <= bus.load_data << 1;
                        end else begin
                            ser_out_q <= bus.load_data[0];
                            shreg     <= bus.load_data >> 1;
                        end
`ifdef SERIAL_BIT_TX_PARITY_EN
                        parity_q <= ^bus.load_data;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(WIDTH)) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
                        state     <= PAR;
                        ser_out_q <= parity_q;
`else
                        state        <= DONE;
                        ser_out_q    <= 1'b0;
                        ser_active_q <= 1'b0;
                        done_q       <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (MSB_FIRST != 0) begin
                            ser_out_q <= shreg[WIDTH-1];
                            shreg     <= shreg << 1;
                        end else begin
                            ser_out_q <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end
                end
`ifdef SERIAL_BIT_TX_PARITY_EN
                PAR: begin
                    state        <= DONE;
                    ser_out_q    <= 1'b0;
                    ser_active_q <= 1'b0;
                    done_q       <= 1'b1;
                end
`endif
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    ready_q      <= 1'b1;
                    ser_out_q    <= 1'b0;
                    ser_active_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: LSB-first and MSB-first instances driven in lockstep,
// serial bits checked against a scoreboard queue, frame timing checked per cycle.
module tb_serial_bit_tx;
    localparam int W = 8;
`ifdef SERIAL_BIT_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [7:0] d;
        logic [7:0] lsb;   // bit i = i-th transmitted bit, LSB-first instance
        logic [7:0] msb;   // bit i = i-th transmitted bit, MSB-first instance
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   q0[$];
    bit   q1[$];
    vec_t tbl[8];

    serial_bit_tx_if #(.WIDTH(W)) if0 ();
    serial_bit_tx_if #(.WIDTH(W)) if1 ();

    serial_bit_tx #(.WIDTH(W), .MSB_FIRST(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serial_bit_tx #(.WIDTH(W), .MSB_FIRST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if0.load_valid = v;
        if1.load_valid = v;
        if0.load_data  = d;
        if1.load_data  = d;
    endtask

    task automatic push_exp(input vec_t v);
        for (int i = 0; i < W; i++) begin
            q0.push_back(v.lsb[i]);
            q1.push_back(v.msb[i]);
        end
        if (P != 0) begin
            q0.push_back(v.par);
            q1.push_back(v.par);
        end
    endtask

    // Scoreboard: every active serial bit must match the next expected one
    always @(negedge clk) begin
        if (rst_n && if0.ser_active) begin
            chk("q0_has_bit", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) chk("ser_out_lsb", 32'(if0.ser_out), 32'(q0.pop_front()));
        end
        if (rst_n && if1.ser_active) begin
            chk("q1_has_bit", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) chk("ser_out_msb", 32'(if1.ser_out), 32'(q1.pop_front()));
        end
    end

    // Full frame from an idle negedge; leaves the bench at the negedge where ready returns.
    task automatic send_frame(input vec_t v, input logic [7:0] chg, input bit release_rst);
        if (release_rst) rst_n = 1'b1;
        chk("ready_before", 32'(if0.load_ready), 32'd1);
        drive(1'b1, v.d);
        push_exp(v);
        tick();
        drive(1'b0, chg);
        for (int k = 1; k <= W + P; k++) begin
            chk("active0", 32'(if0.ser_active), 32'd1);
            chk("active1", 32'(if1.ser_active), 32'd1);
            chk("busy_ready", 32'(if0.load_ready), 32'd0);
            chk("early_done", 32'(if0.done), 32'd0);
            tick();
        end
        chk("done0", 32'(if0.done), 32'd1);
        chk("done1", 32'(if1.done), 32'd1);
        chk("done_active", 32'(if0.ser_active), 32'd0);
        chk("done_out", 32'(if0.ser_out), 32'd0);
        chk("done_ready", 32'(if0.load_ready), 32'd0);
        tick();
        chk("ready_after0", 32'(if0.load_ready), 32'd1);
        chk("ready_after1", 32'(if1.load_ready), 32'd1);
        chk("done_cleared", 32'(if0.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges[2];
        int   acc;
        int   cur;

        tbl[0] = '{d: 8'h0B, lsb: 8'h0B, msb: 8'hD0, par: 1'b1};
        tbl[1] = '{d: 8'hF0, lsb: 8'hF0, msb: 8'h0F, par: 1'b0};
        tbl[2] = '{d: 8'hA5, lsb: 8'hA5, msb: 8'hA5, par: 1'b0};
        tbl[3] = '{d: 8'h01, lsb: 8'h01, msb: 8'h80, par: 1'b1};
        tbl[4] = '{d: 8'h07, lsb: 8'h07, msb: 8'hE0, par: 1'b1};
        tbl[5] = '{d: 8'hFF, lsb: 8'hFF, msb: 8'hFF, par: 1'b0};
        tbl[6] = '{d: 8'h00, lsb: 8'h00, msb: 8'h00, par: 1'b0};
        tbl[7] = '{d: 8'h80, lsb: 8'h80, msb: 8'h01, par: 1'b1};

        // Reset held: load_valid toggling must not start a frame
        drive(1'b0, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'(i % 2 == 0), 8'hFF);
            tick();
            chk("rst_ready", 32'(if0.load_ready), 32'd1);
            chk("rst_active", 32'(if0.ser_active | if1.ser_active), 32'd0);
            chk("rst_out", 32'(if0.ser_out | if1.ser_out), 32'd0);
            chk("rst_done", 32'(if0.done | if1.done), 32'd0);
        end
        drive(1'b0, 8'h00);
        rst_n = 1'b1;
        tick();

        // Table-driven frames; load_data is disturbed right after accept
        for (int r = 0; r < 8; r++) send_frame(tbl[r], ~tbl[r].d, 1'b0);

        // load_valid held high: second word accepted exactly one frame period later
        acc = 0;
        cur = 0;
        drive(1'b1, tbl[0].d);
        for (int n = 0; n < 40 && acc < 2; n++) begin
            if (if0.load_ready) begin
                edges[acc] = n;
                push_exp(tbl[cur]);
                acc++;
            end
            tick();
            if (acc == 1 && cur == 0) begin
                cur = 1;
                drive(1'b1, tbl[1].d);
            end
        end
        drive(1'b0, 8'h00);
        chk("b2b_accepts", 32'(acc), 32'd2);
        if (acc == 2) chk("b2b_spacing", 32'(edges[1] - edges[0]), 32'(W + 2 + P));
        for (int k = 0; k < W + P + 1; k++) tick();
        chk("b2b_ready", 32'(if0.load_ready), 32'd1);
        chk("b2b_drained", 32'(q0.size() + q1.size()), 32'd0);

        // Reset after three bits of 0xA5: immediate return to idle, no done
        drive(1'b1, tbl[2].d);
        push_exp(tbl[2]);
        tick();
        drive(1'b0, 8'h00);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_active", 32'(if0.ser_active | if1.ser_active), 32'd0);
        chk("abort_out", 32'(if0.ser_out | if1.ser_out), 32'd0);
        chk("abort_ready", 32'(if0.load_ready), 32'd1);
        chk("abort_done", 32'(if0.done), 32'd0);
        q0.delete();
        q1.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 32'(if0.done | if1.done), 32'd0);
        end
        send_frame(tbl[3], 8'hFF, 1'b1);

        chk("final_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
